// File: rtl/buffer_pkg.sv
// Shared definitions for the buffer subsystem: width defaults and the drain FSM encoding.
package buffer_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LEN_W_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } drain_state_t;

endpackage

// File: rtl/buffer_skid.sv
// Two-entry register FIFO; absorbs the one-cycle read latency of the upstream FIFO.
module buffer_skid
  import buffer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             pop_ok;

  assign pop_ok = pop && (occ != 2'd0);
  assign dout   = head;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: both entries are reset, since the head drives the output data whose reset value is 0.
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
    end else begin
      assert (!(push && occ == 2'd2));
      case ({push, pop_ok})
        2'b10: begin
          if (occ == 2'd0) head <= din;
          else             tail <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: the new word lands behind whatever remains.
          if (occ == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/buffer_drain.sv
// Read-side controller: pops a commanded number of words from the FIFO and re-issues them
// on a valid/ready stream with a last-beat marker and a completion pulse.
module buffer_drain
  import buffer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             fifo_read_en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             done,
  output logic             busy
);

  drain_state_t     state;
  logic [LEN_W-1:0] issue_left;
  logic [LEN_W-1:0] beats_left;
  logic             inflight;
  logic [1:0]       occ;
  logic             pop;
  logic [2:0]       pending;

  assign pop     = m_valid && m_ready;
  assign pending = {1'b0, occ} + {2'b0, inflight};

  // Occupancy after this cycle's handshake must leave room for the word about to be popped.
  assign fifo_read_en = (state == RUN) && (issue_left != '0) && !fifo_empty
                        && (pending < (3'd2 + {2'b0, pop}));

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign m_valid   = (occ != 2'd0);
  assign m_last    = m_valid && (beats_left == LEN_W'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      issue_left <= '0;
      beats_left <= '0;
      inflight   <= 1'b0;
    end else begin
      inflight <= fifo_read_en;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            issue_left <= cmd_len;
            beats_left <= cmd_len;
            state      <= (cmd_len != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (fifo_read_en) issue_left <= issue_left - LEN_W'(1);
          if (pop) begin
            beats_left <= beats_left - LEN_W'(1);
            if (beats_left == LEN_W'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  buffer_skid #(.WIDTH(WIDTH)) u_skid (
    .CLK  (CLK),
    .RST  (RST),
    .push (inflight),
    .pop  (pop),
    .din  (fifo_dout),
    .dout (m_data),
    .occ  (occ)
  );

endmodule
